// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller between decode and the execute-stage pipeline register.
// A per-register counter scoreboard tracks in-flight writes and holds decode
// on RAW hazards or saturated counters. A redirecting commit flushes the pipe.
module issue_scoreboard_ctrl #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_wen,
    input  logic            ex_ready,
    output logic            issue_valid,
    input  logic            wb_commit,
    input  logic [4:0]      wb_rd,
    input  logic            wb_rd_wen,
    input  logic            wb_redirect,
    output logic            flush,
    output logic [NREG-1:0] busy_vec,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  reg_busy;
    logic             wb_wr;
    logic             busy1, busy2, rd_full;
    logic             hazard;
    logic             fire;
    logic [31:0]      stall_cycles_q, flush_count_q;

    assign wb_wr = wb_commit & wb_rd_wen;

    // Per-register busy view; a last write retiring this cycle is forwarded when bypass is on.
    always_comb begin
        reg_busy = '0;
        for (int r = 1; r < int'(NREG); r++) begin
            reg_busy[r] = (cnt_q[r] != '0) &&
                          !(WB_BYPASS && wb_wr && (wb_rd == 5'(r)) && (cnt_q[r] == CntOne));
        end
    end

    // Select the busy state of each decode operand; x0 is never matched.
    always_comb begin
        busy1   = 1'b0;
        busy2   = 1'b0;
        rd_full = 1'b0;
        for (int r = 1; r < int'(NREG); r++) begin
            if (id_rs1 == 5'(r)) busy1 = reg_busy[r];
            if (id_rs2 == 5'(r)) busy2 = reg_busy[r];
            if (id_rd == 5'(r)) rd_full = (cnt_q[r] == CntMax);
        end
    end

    assign hazard = (id_rs1_used & busy1) | (id_rs2_used & busy2) | (id_rd_wen & rd_full);

    // Handshake outputs are held low while reset is asserted.
    assign flush       = rst & wb_commit & wb_redirect;
    assign issue_valid = rst & id_valid & ~hazard & ~flush;
    assign id_ready    = rst & ex_ready & ~hazard & ~flush;
    assign fire        = id_valid & id_ready;

    // Counter next state: issue increments, commit decrements, flush clears everything.
    always_comb begin
        for (int r = 0; r < int'(NREG); r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (r != 0) begin
                if (fire && id_rd_wen && (id_rd == 5'(r)) && !(wb_wr && (wb_rd == 5'(r)))) begin
                    if (cnt_q[r] != CntMax) cnt_d[r] = cnt_q[r] + CntOne;
                end else if (wb_wr && (wb_rd == 5'(r)) &&
                             !(fire && id_rd_wen && (id_rd == 5'(r)))) begin
                    // Underflow is a protocol error; hold at zero.
                    if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CntOne;
                end
            end
        end
    end

    // Scoreboard counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (id_valid && hazard && !flush) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

    // Busy vector follows the registered counters.
    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < int'(NREG); r++) busy_vec[r] = (cnt_q[r] != '0);
    end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Directed bench for issue_scoreboard_ctrl; runs a bypass and a non-bypass instance side by side.
module tb_issue_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wen, ex_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        wb_commit, wb_rd_wen, wb_redirect;

    logic        iv1, ir1, fl1, iv0, ir0, fl0;
    logic [31:0] bv1, sc1, fc1, bv0, sc0, fc0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    issue_scoreboard_ctrl #(.NREG(32), .CNT_W(2), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(ir1),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .ex_ready(ex_ready), .issue_valid(iv1),
        .wb_commit(wb_commit), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen), .wb_redirect(wb_redirect),
        .flush(fl1), .busy_vec(bv1), .stall_cycles(sc1), .flush_count(fc1)
    );

    issue_scoreboard_ctrl #(.NREG(32), .CNT_W(2), .WB_BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(ir0),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .ex_ready(ex_ready), .issue_valid(iv0),
        .wb_commit(wb_commit), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen), .wb_redirect(wb_redirect),
        .flush(fl0), .busy_vec(bv0), .stall_cycles(sc0), .flush_count(fc0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_wen = wen;
    endtask

    task automatic set_wb(input logic c, input logic [4:0] rd, input logic wen, input logic redir);
        wb_commit = c; wb_rd = rd; wb_rd_wen = wen; wb_redirect = redir;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0, 1'b0, 1'b0);
        ex_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
        set_wb(1'b1, 5'd0, 1'b0, 1'b1);
        ex_ready = 1'b1;
        #1;
        total++; if (iv1 !== 1'b0) begin bad++; $display("FAIL rst_issue_valid: got %b want 0", iv1); end
        total++; if (ir1 !== 1'b0) begin bad++; $display("FAIL rst_id_ready: got %b want 0", ir1); end
        total++; if (fl1 !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", fl1); end
        tick();
        total++; if (bv1 !== 32'd0) begin bad++; $display("FAIL rst_busy_vec: got %h want 0", bv1); end
        total++; if (sc1 !== 32'd0 || fc1 !== 32'd0) begin
            bad++; $display("FAIL rst_perf: got stall=%0d flush=%0d want 0 0", sc1, fc1);
        end
        idle();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        total++; if (iv1 !== 1'b1 || ir1 !== 1'b1) begin
            bad++; $display("FAIL byp_producer: got v=%b r=%b want 1 1", iv1, ir1);
        end
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        #1;
        total++; if (iv1 !== 1'b0 || iv0 !== 1'b0) begin
            bad++; $display("FAIL byp_consumer_stall: got %b/%b want 0/0", iv1, iv0);
        end
        total++; if (bv1[5] !== 1'b1) begin bad++; $display("FAIL byp_busy5: got %b want 1", bv1[5]); end
        tick();
        total++; if (sc1 !== 32'd1 || iv1 !== 1'b0) begin
            bad++; $display("FAIL byp_stall1: got sc=%0d v=%b want 1 0", sc1, iv1);
        end
        tick();
        set_wb(1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        total++; if (iv1 !== 1'b1) begin bad++; $display("FAIL byp_issue_on_commit: got %b want 1", iv1); end
        total++; if (iv0 !== 1'b0) begin bad++; $display("FAIL nobyp_hold_on_commit: got %b want 0", iv0); end
        total++; if (sc1 !== 32'd2) begin bad++; $display("FAIL byp_stall2: got %0d want 2", sc1); end
        tick();
        set_wb(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        total++; if (bv1[5] !== 1'b0 || bv0[5] !== 1'b0) begin
            bad++; $display("FAIL byp_busy5_clear: got %b/%b want 0/0", bv1[5], bv0[5]);
        end
        total++; if (iv0 !== 1'b1) begin bad++; $display("FAIL nobyp_issue_late: got %b want 1", iv0); end
        total++; if (sc0 !== 32'd3 || sc1 !== 32'd2) begin
            bad++; $display("FAIL byp_stall_final: got %0d/%0d want 2/3", sc1, sc0);
        end
        tick();
        idle();
        #1;
        total++; if (bv1[6] !== 1'b1) begin bad++; $display("FAIL byp_busy6: got %b want 1", bv1[6]); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (iv1 !== 1'b1) begin bad++; $display("FAIL full_w%0d: got %b want 1", i, iv1); end
            tick();
        end
        #1;
        total++; if (iv1 !== 1'b0 || ir1 !== 1'b0) begin
            bad++; $display("FAIL full_w4_stall: got v=%b r=%b want 0 0", iv1, ir1);
        end
        total++; if (bv1[7] !== 1'b1) begin bad++; $display("FAIL full_busy7: got %b want 1", bv1[7]); end
        tick();
        set_wb(1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        total++; if (iv1 !== 1'b0) begin bad++; $display("FAIL full_commit_at_max: got %b want 0", iv1); end
        tick();
        #1;
        total++; if (iv1 !== 1'b1) begin bad++; $display("FAIL full_issue_and_commit: got %b want 1", iv1); end
        tick();
        set_wb(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        total++; if (iv1 !== 1'b1) begin bad++; $display("FAIL full_refill: got %b want 1", iv1); end
        total++; if (sc1 !== 32'd2) begin bad++; $display("FAIL full_stalls: got %0d want 2", sc1); end
        tick();
        #1;
        total++; if (iv1 !== 1'b0) begin bad++; $display("FAIL full_again: got %b want 0", iv1); end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        set_wb(1'b1, 5'd0, 1'b0, 1'b1);
        #1;
        total++; if (fl1 !== 1'b1) begin bad++; $display("FAIL flush_assert: got %b want 1", fl1); end
        total++; if (iv1 !== 1'b0 || ir1 !== 1'b0) begin
            bad++; $display("FAIL flush_no_issue: got v=%b r=%b want 0 0", iv1, ir1);
        end
        total++; if (bv1 !== 32'h0000_0208) begin bad++; $display("FAIL flush_busy_pre: got %h want 00000208", bv1); end
        tick();
        idle();
        #1;
        total++; if (fl1 !== 1'b0) begin bad++; $display("FAIL flush_one_cycle: got %b want 0", fl1); end
        total++; if (bv1 !== 32'd0) begin bad++; $display("FAIL flush_busy_post: got %h want 0", bv1); end
        total++; if (fc1 !== 32'd1) begin bad++; $display("FAIL flush_count: got %0d want 1", fc1); end
        total++; if (sc1 !== 32'd0) begin bad++; $display("FAIL flush_no_stall: got %0d want 0", sc1); end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        total++; if (iv1 !== 1'b1) begin bad++; $display("FAIL x0_writer: got %b want 1", iv1); end
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        set_wb(1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        total++; if (iv1 !== 1'b1 || ir1 !== 1'b1) begin
            bad++; $display("FAIL x0_reader: got v=%b r=%b want 1 1", iv1, ir1);
        end
        tick();
        idle();
        #1;
        total++; if (bv1 !== 32'd0 || sc1 !== 32'd0) begin
            bad++; $display("FAIL x0_state: got bv=%h sc=%0d want 0 0", bv1, sc1);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_wb(1'b1, 5'd0, 1'b0, 1'b1);
        tick();
        set_wb(1'b0, 5'd0, 1'b0, 1'b0);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        tick();
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
        repeat (17) tick();
        total++; if (sc1 !== 32'd17 || fc1 !== 32'd1 || bv1[4] !== 1'b1 || iv1 !== 1'b0) begin
            bad++; $display("FAIL arst_pre: got sc=%0d fc=%0d b4=%b v=%b want 17 1 1 0",
                            sc1, fc1, bv1[4], iv1);
        end
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0);
        rst = 1'b0;
        #1;
        total++; if (bv1 !== 32'd0 || sc1 !== 32'd0 || fc1 !== 32'd0) begin
            bad++; $display("FAIL arst_clear: got bv=%h sc=%0d fc=%0d want 0 0 0", bv1, sc1, fc1);
        end
        total++; if (iv1 !== 1'b0 || ir1 !== 1'b0) begin
            bad++; $display("FAIL arst_handshake: got v=%b r=%b want 0 0", iv1, ir1);
        end
        tick();
        tick();
        total++; if (iv1 !== 1'b0 || ir1 !== 1'b0) begin
            bad++; $display("FAIL arst_hold: got v=%b r=%b want 0 0", iv1, ir1);
        end
        rst = 1'b1;
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
        #1;
        total++; if (iv1 !== 1'b1) begin bad++; $display("FAIL arst_release: got %b want 1", iv1); end
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_full();
        test_flush();
        test_x0();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
